mem_ctrl: RTL
=============

# mem_ctrl

Memory controller between the pipeline's access stages and the byte-wide RAM/IO bus. It arbitrates between the instruction-fetch port (word reads) and the data port driven by the MEM stage (byte/half/word reads and writes). It serialises each access into little-endian single-byte RAM cycles and reports completion through per-port status codes. The MEM stage holds its request asserted until it observes Handled, then drops it combinationally in the same cycle.

## Interface
Parameters: none. Encodings are fixed:
- status: 2'b00 None, 2'b01 Busy, 2'b10 Handled
- type: 2'b00 Byte, 2'b01 Half, 2'b10 Word, 2'b11 treated as Word
- sel: 0 Read, 1 Write

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- if_enable  in  1  instruction-fetch request (word read)
- if_addr  in  32  fetch byte address
- if_stat  out  2  fetch-port status
- if_dout  out  32  fetched word
- mem_enable  in  1  data-port request
- mem_sel  in  1  Read/Write
- mem_type  in  2  access size
- mem_addr  in  32  data byte address
- mem_din  in  32  store data; bytes above the access size are ignored
- mem_stat  out  2  data-port status
- mem_dout  out  32  load data, zero-extended (MEM performs sign extension)
- ram_din  in  8  RAM read byte, valid one cycle after its address
- io_buffer_full  in  1  IO sink cannot accept a byte
- ram_wr  out  1  RAM write strobe
- ram_a  out  32  RAM byte address
- ram_dout  out  8  RAM write byte

## Operation
- Byte count N: Byte 1, Half 2, Word 4.
- States:
  - IDLE: stats None.
  - READ
  - WRITE
  - DONE: served port's stat is Handled for exactly one cycle; the other port's stat is None; then go to IDLE.
- Accepting a request (IDLE only):
  - The controller samples requests at the clock edge.
  - mem_enable has priority over if_enable.
  - On accept, latch port id, addr, type, sel and din; served port's stat becomes Busy.
  - A waiting port sees None.
  - An accepted transaction is never preempted.
  - Requests arriving in READ, WRITE or DONE are ignored until IDLE.
- READ (N bytes, cycles k=0..N):
  - ram_wr=0.
  - ram_a=addr+k for k<N.
  - At the end of cycle k≥1, capture ram_din into bits [8(k-1)+7 : 8(k-1)].
  - After capturing byte N-1, go to DONE.
- WRITE (cycles k=0..N-1):
  - ram_wr=1, ram_a=addr+k, ram_dout=din[8k+7:8k].
  - After byte N-1, go to DONE.
- Outputs:
  - if_dout/mem_dout update only on completion of a read for that port, and hold until the next such completion.
  - Unused upper bytes are zero.
- Addresses: addr+k is computed as 32-bit wrap-around arithmetic. There is no alignment requirement.

## Timing
- All outputs are registered.
- Reset values: ram_wr=0, ram_a=0, ram_dout=0, if_stat=None, mem_stat=None, if_dout=0, mem_dout=0, state IDLE.
- Latency is counted from the accepting edge to the cycle Handled is visible:
  - read: N+2 cycles (Word: 6)
  - write: N+1 cycles (Word: 5)
- Throughput: minimum one idle cycle between transactions (the DONE→IDLE cycle). Back-to-back requests are accepted on the edge ending IDLE.
- Simultaneous if_enable and mem_enable in IDLE: data port is served first. The fetch is served in the next IDLE if still asserted.
- rst during READ/WRITE/DONE:
  - abort; return to IDLE with reset values on the next edge
  - no further RAM write occurs
  - no Handled is issued
- If a request drops before completion, the transaction still runs to completion. Handled is still pulsed.

## Configuration
- Macro MEMCTRL_IO_STALL_EN.
- Defined:
  - Applies to a WRITE byte with ram_a[17:16]==2'b11 while io_buffer_full=1.
  - The controller holds k, drives ram_wr=0, and keeps ram_a/ram_dout steady.
  - It resumes when io_buffer_full=0.
  - Write latency grows by the number of stalled cycles.
- Undefined: io_buffer_full is ignored. Writes proceed at one byte per cycle.

## Test plan
- Word read, mem_addr=0x100, RAM[0x100..0x103]=11,22,33,44 → ram_a 0x100..0x103 on consecutive cycles; mem_stat Handled one cycle at accept+6; mem_dout=0x44332211.
- Half write, mem_addr=0x202, mem_din=0xDEADBEEF → ram_wr=1 for two cycles, bytes EF@0x202 and BE@0x203; Handled at accept+3; RAM[0x204] unchanged.
- if_enable and mem_enable both asserted in the same cycle (mem Byte read 0x10 = 0x9A, fetch 0x0 = 0x00000013):
  - mem_dout=0x0000009A first, with if_stat None meanwhile
  - then if_dout=0x00000013
- Byte read wrap at addr 0xFFFFFFFF followed by Word read → no ram_a beyond 0xFFFFFFFF for the byte; the next access is accepted exactly one cycle after DONE.
- rst asserted during cycle k=1 of a Word write to 0x300:
  - only byte 0 written
  - outputs return to reset values next cycle
  - no Handled
- With MEMCTRL_IO_STALL_EN: Byte write 0x41 to 0x30000 with io_buffer_full=1 for 3 cycles → ram_wr=0 for those cycles, then one write of 0x41; Handled at accept+5. Without the macro: Handled at accept+2.

Source files
------------

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates fetch and data ports onto a byte-wide RAM/IO bus.
// Optional macro MEMCTRL_IO_STALL_EN stalls IO writes (ram_a[17:16]==2'b11) while io_buffer_full.
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_enable,
    input  logic [31:0] if_addr,
    output logic [1:0]  if_stat,
    output logic [31:0] if_dout,
    input  logic        mem_enable,
    input  logic        mem_sel,
    input  logic [1:0]  mem_type,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_din,
    output logic [1:0]  mem_stat,
    output logic [31:0] mem_dout,
    input  logic [7:0]  ram_din,
    input  logic        io_buffer_full,
    output logic        ram_wr,
    output logic [31:0] ram_a,
    output logic [7:0]  ram_dout
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [1:0] ST_NONE    = 2'b00;
    localparam logic [1:0] ST_BUSY    = 2'b01;
    localparam logic [1:0] ST_HANDLED = 2'b10;

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic        port_mem, port_mem_nxt;
    logic [31:0] addr_q, addr_nxt;
    logic [1:0]  type_q, type_nxt;
    logic [31:0] din_q, din_nxt;
    logic [31:0] rbuf, rbuf_nxt;

    logic        ram_wr_nxt;
    logic [31:0] ram_a_nxt;
    logic [7:0]  ram_dout_nxt;
    logic [1:0]  if_stat_nxt, mem_stat_nxt;
    logic [31:0] if_dout_nxt, mem_dout_nxt;

    logic [2:0]  nbytes;
    logic [31:0] byte_a;
    logic [2:0]  cap_idx;
    logic        stall;

    function automatic logic [2:0] byte_count(input logic [1:0] t);
        case (t)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [7:0] lane(input logic [31:0] w, input logic [1:0] i);
        return w[{i, 3'b000} +: 8];
    endfunction

`ifndef MEMCTRL_IO_STALL_EN
    logic unused_io_full;
    assign unused_io_full = io_buffer_full;
`endif

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        port_mem_nxt = port_mem;
        addr_nxt     = addr_q;
        type_nxt     = type_q;
        din_nxt      = din_q;
        rbuf_nxt     = rbuf;
        ram_wr_nxt   = 1'b0;
        ram_a_nxt    = ram_a;
        ram_dout_nxt = ram_dout;
        if_stat_nxt  = if_stat;
        mem_stat_nxt = mem_stat;
        if_dout_nxt  = if_dout;
        mem_dout_nxt = mem_dout;
        nbytes       = byte_count(type_q);
        byte_a       = addr_q + {29'd0, cnt};
        cap_idx      = cnt - 3'd2;
        stall        = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt  = 3'd0;
                rbuf_nxt = 32'd0;
                if (mem_enable) begin
                    port_mem_nxt = 1'b1;
                    addr_nxt     = mem_addr;
                    type_nxt     = mem_type;
                    din_nxt      = mem_din;
                    mem_stat_nxt = ST_BUSY;
                    state_nxt    = mem_sel ? WRITE : READ;
                end else if (if_enable) begin
                    port_mem_nxt = 1'b0;
                    addr_nxt     = if_addr;
                    type_nxt     = 2'b10;
                    din_nxt      = 32'd0;
                    if_stat_nxt  = ST_BUSY;
                    state_nxt    = READ;
                end
            end

            // Byte cnt is addressed while cnt < N; its data is captured two edges later.
            READ: begin
                if (cnt < nbytes)
                    ram_a_nxt = byte_a;
                if (cnt >= 3'd2)
                    rbuf_nxt[{cap_idx[1:0], 3'b000} +: 8] = ram_din;
                if (cnt == nbytes + 3'd1) begin
                    state_nxt = DONE;
                    if (port_mem) begin
                        mem_stat_nxt = ST_HANDLED;
                        mem_dout_nxt = rbuf_nxt;
                    end else begin
                        if_stat_nxt = ST_HANDLED;
                        if_dout_nxt = rbuf_nxt;
                    end
                end else begin
                    cnt_nxt = cnt + 3'd1;
                end
            end

            WRITE: begin
                if (cnt < nbytes) begin
                    ram_a_nxt    = byte_a;
                    ram_dout_nxt = lane(din_q, cnt[1:0]);
`ifdef MEMCTRL_IO_STALL_EN
                    stall = (byte_a[17:16] == 2'b11) && io_buffer_full;
`endif
                    ram_wr_nxt = !stall;
                    if (!stall)
                        cnt_nxt = cnt + 3'd1;
                end else begin
                    state_nxt = DONE;
                    if (port_mem)
                        mem_stat_nxt = ST_HANDLED;
                    else
                        if_stat_nxt = ST_HANDLED;
                end
            end

            default: begin
                if_stat_nxt  = ST_NONE;
                mem_stat_nxt = ST_NONE;
                state_nxt    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            ram_wr   <= 1'b0;
            ram_a    <= 32'd0;
            ram_dout <= 8'd0;
            if_stat  <= ST_NONE;
            mem_stat <= ST_NONE;
            if_dout  <= 32'd0;
            mem_dout <= 32'd0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            ram_wr   <= ram_wr_nxt;
            ram_a    <= ram_a_nxt;
            ram_dout <= ram_dout_nxt;
            if_stat  <= if_stat_nxt;
            mem_stat <= mem_stat_nxt;
            if_dout  <= if_dout_nxt;
            mem_dout <= mem_dout_nxt;
        end
    end

    // Transaction data needs no reset: it is always loaded on accept before use.
    always_ff @(posedge clk) begin
        port_mem <= port_mem_nxt;
        addr_q   <= addr_nxt;
        type_q   <= type_nxt;
        din_q    <= din_nxt;
        rbuf     <= rbuf_nxt;
    end
endmodule
